// File: rtl/pu_pipe_if.sv
// Handshake bundle for pu_pipe: operand input side and result output side.
interface pu_pipe_if #(
  parameter int XLEN  = 5,
  parameter int LANES = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*XLEN-1:0]   nums;
  logic                    mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         result;

  modport master (
    output in_valid, nums, mode, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, nums, mode, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/pu_pipe.sv
// Pipelined lane summer: registered operand stage feeding a registered binary adder tree.
// Define PU_PIPE_SAT_EN to make every adder level saturate instead of wrap.
module pu_pipe #(
  parameter int XLEN  = 5,
  parameter int LANES = 4
) (
  input  logic      clk,
  input  logic      rst,
  pu_pipe_if.slave  bus
);
  localparam int LEVELS = $clog2(LANES);
  localparam int NODES  = 2 * LANES;

  // Heap-ordered tree: node 1 is the root, leaves LANES..2*LANES-1 form stage 0.
  logic [XLEN-1:0] node_reg [1:NODES-1];
  logic [LEVELS:0] vld_reg;
  logic [XLEN-1:0] lane_next [LANES];
  logic            stall;
  logic            adv;

  assign stall         = vld_reg[LEVELS] && !bus.out_ready;
  assign adv           = !stall;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_reg[LEVELS];
  assign bus.result    = node_reg[1];

  function automatic logic [XLEN-1:0] add_node(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
`ifdef PU_PIPE_SAT_EN
    logic [XLEN:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[XLEN] ? {XLEN{1'b1}} : s[XLEN-1:0];
`else
    return a + b;
`endif
  endfunction

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [XLEN-1:0] raw;
      assign raw = bus.nums[gi*XLEN +: XLEN];
      if (gi == 0) begin : g_exact
        assign lane_next[gi] = raw;
      end else begin : g_approx
        assign lane_next[gi] = bus.mode ? {3'b100, raw[XLEN-2 -: XLEN-3]} : raw;
      end
    end
  endgenerate

  // One valid bit per stage; a global advance keeps bubbles and data aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
    end else if (adv) begin
      vld_reg <= {vld_reg[LEVELS-1:0], bus.in_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 1; n < NODES; n++) begin
        node_reg[n] <= '0;
      end
    end else if (adv) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.in_valid) begin
          node_reg[LANES + i] <= lane_next[i];
        end
      end
      // Node n sits at level LEVELS - floor(log2 n); its children one level below.
      for (int n = 1; n < LANES; n++) begin
        if (vld_reg[LEVELS - $clog2(n + 1)]) begin
          node_reg[n] <= add_node(node_reg[2*n], node_reg[2*n + 1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_pu_pipe.sv
// Directed self-checking bench for pu_pipe (XLEN=5, LANES=4); honours PU_PIPE_SAT_EN.
module tb_pu_pipe;
  localparam int XLEN  = 5;
  localparam int LANES = 4;

`ifdef PU_PIPE_SAT_EN
  localparam int APPROX_EXP = 31;
`else
  localparam int APPROX_EXP = 25;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  pu_pipe_if #(.XLEN(XLEN), .LANES(LANES)) bus ();

  pu_pipe #(.XLEN(XLEN), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [LANES*XLEN-1:0] pack(input int l0, input int l1,
                                                 input int l2, input int l3);
    logic [XLEN-1:0] a0, a1, a2, a3;
    a0 = l0[XLEN-1:0];
    a1 = l1[XLEN-1:0];
    a2 = l2[XLEN-1:0];
    a3 = l3[XLEN-1:0];
    return {a3, a2, a1, a0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.nums      = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_result", {27'd0, bus.result}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Exact sum and latency
    bus.nums     = pack(1, 2, 3, 4);
    bus.mode     = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("exact_lat1", {31'd0, bus.out_valid}, 32'd0);
    step();
    chk("exact_lat2", {31'd0, bus.out_valid}, 32'd0);
    step();
    chk("exact_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("exact_sum", {27'd0, bus.result}, 32'd10);
    step();
    chk("exact_pulse", {31'd0, bus.out_valid}, 32'd0);
    chk("exact_hold", {27'd0, bus.result}, 32'd10);

    // Approximated lanes
    bus.nums     = pack(3, 12, 0, 31);
    bus.mode     = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.mode     = 1'b0;
    step();
    step();
    chk("approx_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("approx_sum", {27'd0, bus.result}, APPROX_EXP);
    step();

    // Back-pressure with a held bundle accepted on release
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.nums      = pack(1, 1, 1, 1);
    step();
    bus.nums = pack(2, 2, 2, 2);
    step();
    bus.nums = pack(3, 3, 3, 3);
    step();
    bus.nums = pack(5, 5, 5, 5);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_stall_valid%0d", k), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp_stall_ready%0d", k), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("bp_stall_result%0d", k), {27'd0, bus.result}, 32'd4);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_res0", {27'd0, bus.result}, 32'd4);
    step();
    bus.in_valid = 1'b0;
    chk("bp_valid1", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_res1", {27'd0, bus.result}, 32'd8);
    step();
    chk("bp_valid2", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_res2", {27'd0, bus.result}, 32'd12);
    step();
    chk("bp_valid3", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_res3", {27'd0, bus.result}, 32'd20);
    step();
    chk("bp_drain", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_hold", {27'd0, bus.result}, 32'd20);

    // Reset mid-flight
    bus.nums     = pack(1, 2, 3, 4);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rstmid_valid%0d", k), {31'd0, bus.out_valid}, 32'd0);
      chk($sformatf("rstmid_result%0d", k), {27'd0, bus.result}, 32'd0);
      step();
    end

    // Bubbles
    bus.nums     = pack(4, 4, 4, 4);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    bus.nums     = pack(7, 0, 0, 0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("bub_valid0", {31'd0, bus.out_valid}, 32'd1);
    chk("bub_res0", {27'd0, bus.result}, 32'd16);
    step();
    chk("bub_valid1", {31'd0, bus.out_valid}, 32'd0);
    chk("bub_hold1", {27'd0, bus.result}, 32'd16);
    step();
    chk("bub_valid2", {31'd0, bus.out_valid}, 32'd1);
    chk("bub_res2", {27'd0, bus.result}, 32'd7);
    step();
    chk("bub_end", {31'd0, bus.out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
